// File: rtl/serial_rx_word.sv
// serial_rx_word: 8N1 serial receiver that assembles 3-byte words.
// Define SERIAL_RX_MAJORITY_EN for 2-of-3 majority sampling of rx.
module serial_rx_word #(
  parameter int CLK_PER_BIT  = 250,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic [7:0]  data,
  output logic        new_data,
  output logic        frame_error,
  output logic [23:0] word,
  output logic        new_word,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
  localparam logic [15:0] HALF_END = 16'(CLK_PER_BIT / 2 - 1);
  localparam logic [15:0] BIT_END  = 16'(CLK_PER_BIT - 1);
  localparam logic [31:0] IDLE_MAX = 32'(TIMEOUT_BITS * CLK_PER_BIT);
  state_t      state, state_nxt;
  logic        rx_m, rx_s, sample, tick_half, tick_bit, ld, fe;
  logic [15:0] ctr;
  logic [2:0]  bit_idx;
  logic [7:0]  sh;
  logic [1:0]  byte_idx;
  logic [15:0] part;
  logic [31:0] idle_cnt;
  always_ff @(posedge clk)
    if (rst) {rx_m, rx_s} <= 2'b11;
    else {rx_m, rx_s} <= {rx, rx_m};
`ifdef SERIAL_RX_MAJORITY_EN
  logic [1:0] hist;
  always_ff @(posedge clk)
    hist <= rst ? 2'b11 : {hist[0], rx_s};
  assign sample = (rx_s & hist[0]) | (rx_s & hist[1]) | (hist[0] & hist[1]);
`else
  assign sample = rx_s;
`endif
  assign tick_half = ctr == HALF_END;
  assign tick_bit  = ctr == BIT_END;
  always_ff @(posedge clk)
    if (rst) begin
      state   <= IDLE;
      ctr     <= '0;
      bit_idx <= '0;
      sh      <= '0;
    end else begin
      state   <= state_nxt;
      ctr     <= (state_nxt != state || state == IDLE || state == BREAK || (state == DATA && tick_bit)) ? '0 : ctr + 16'd1;
      bit_idx <= state == DATA ? bit_idx + {2'b00, tick_bit} : '0;
      if (state == DATA && tick_bit) sh <= {sample, sh[7:1]};
    end
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = rx_s ? IDLE : START;
      START:   if (tick_half) state_nxt = sample ? IDLE : DATA;
      DATA:    if (tick_bit && bit_idx == 3'd7) state_nxt = STOP;
      STOP:    if (tick_bit) state_nxt = sample ? IDLE : BREAK;
      BREAK:   if (rx_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_comb begin
    busy = state != IDLE;
    ld   = state == STOP && tick_bit && sample;
    fe   = state == STOP && tick_bit && !sample;
  end
  // Partial bytes stay in part so word only ever holds complete 3-byte words.
  always_ff @(posedge clk)
    if (rst) begin
      data        <= '0;
      new_data    <= 1'b0;
      frame_error <= 1'b0;
      word        <= '0;
      new_word    <= 1'b0;
      byte_idx    <= '0;
      part        <= '0;
      idle_cnt    <= '0;
    end else begin
      new_data    <= ld;
      frame_error <= fe;
      new_word    <= ld && byte_idx == 2'd2;
      idle_cnt    <= state != IDLE ? '0 : idle_cnt + {31'd0, idle_cnt != IDLE_MAX};
      if (ld) begin
        data     <= sh;
        byte_idx <= byte_idx == 2'd2 ? 2'd0 : byte_idx + 2'd1;
        if (byte_idx == 2'd0) part[15:8] <= sh;
        if (byte_idx == 2'd1) part[7:0] <= sh;
        if (byte_idx == 2'd2) word <= {part, sh};
      end else if (fe || idle_cnt == IDLE_MAX) byte_idx <= '0;
    end
endmodule

// File: doc/serial_rx_word.md
SERIAL_RX_WORD -- requirements
Module: serial_rx_word

Interface
REQ-001 Parameter CLK_PER_BIT, default 250, clk cycles per serial bit; legal range 16 to 65535.
REQ-002 Parameter TIMEOUT_BITS, default 20, idle bit periods after which a partial word is discarded.
REQ-003 Port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Port rx  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-006 Port data  output  8  last correctly framed byte.
REQ-007 Port new_data  output  1  one-cycle pulse when data updates.
REQ-008 Port frame_error  output  1  one-cycle pulse when the stop bit is sampled low.
REQ-009 Port word  output  24  last assembled 3-byte word, first received byte in [23:16].
REQ-010 Port new_word  output  1  one-cycle pulse when word updates.
REQ-011 Port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-012 rx SHALL pass through a 2-flop synchronizer, both flops reset to 1; all decisions use the synchronized value rx_s.
REQ-013 FSM states SHALL be IDLE, START, DATA, STOP and BREAK, with one cycle counter ctr (16 bits) and one bit index (3 bits).
REQ-014 IDLE: rx_s==0 SHALL move to START with ctr=0.
REQ-015 START: at ctr==CLK_PER_BIT/2-1, rx_s==0 SHALL move to DATA with ctr=0 and bit index=0; rx_s==1 SHALL return to IDLE (glitch rejection) with no output pulse.
REQ-016 DATA: at ctr==CLK_PER_BIT-1 the sample SHALL be shifted in LSB first and ctr cleared; after bit index 7 the FSM SHALL move to STOP.
REQ-017 STOP: at ctr==CLK_PER_BIT-1, a sample of 1 SHALL load data and pulse new_data and move to IDLE; a sample of 0 SHALL pulse frame_error, leave data unchanged and move to BREAK.
REQ-018 BREAK: the FSM SHALL stay until rx_s==1, then move to IDLE; a held-low line SHALL produce exactly one frame_error.
REQ-019 new_data SHALL assert 2+CLK_PER_BIT/2+9*CLK_PER_BIT cycles (±1) after the rx falling edge.
REQ-020 The assembler SHALL keep a 2-bit byte index (0..2); each new_data byte SHALL be stored to word slot [23:16], [15:8], [7:0] by index.
REQ-021 On the byte at index 2, word SHALL update and new_word SHALL pulse in the same cycle as that byte's new_data, and the index SHALL return to 0.
REQ-022 frame_error SHALL clear the byte index to 0 without changing word.
REQ-023 An idle counter SHALL count cycles spent in IDLE and clear on leaving IDLE; on reaching TIMEOUT_BITS*CLK_PER_BIT with index!=0 the index SHALL clear to 0; the counter SHALL saturate.
REQ-024 new_data, new_word and frame_error SHALL never assert for more than one consecutive cycle.

Reset
REQ-025 rst SHALL force IDLE, ctr=0, bit index=0, byte index=0, idle counter=0, synchronizer flops=1.
REQ-026 On reset, data=8'h00, word=24'h000000, new_data=0, new_word=0, frame_error=0, busy=0.
REQ-027 rst asserted mid-byte SHALL abandon the byte with no pulse; reception SHALL restart on the next falling edge after rst drops.

Configuration
REQ-028 Macro SERIAL_RX_MAJORITY_EN defined: START, DATA and STOP samples SHALL be the 2-of-3 majority of rx_s at the decision cycle and the two preceding cycles.
REQ-029 Macro SERIAL_RX_MAJORITY_EN undefined: each sample SHALL be the single rx_s value at the decision cycle; all other behaviour unchanged.

Verification
REQ-030 Send 8'hA5 at CLK_PER_BIT=250 -> data=8'hA5, one new_data pulse, no frame_error, busy low within 1 bit after stop.
REQ-031 Send 8'h12, 8'h34, 8'h56 back-to-back -> word=24'h123456, one new_word pulse coincident with third new_data.
REQ-032 Send 8'hFF with stop bit driven low, then hold rx low for 30 bit periods -> exactly one frame_error, data unchanged, byte index 0.
REQ-033 Drive rx low for 100 cycles then high -> no new_data, no frame_error, busy returns to 0.
REQ-034 Send 8'h12, idle 21 bit periods, send 8'h34, 8'h56, 8'h78 -> word=24'h345678, one new_word.
REQ-035 With SERIAL_RX_MAJORITY_EN, send 8'h00 with a 1-cycle high glitch at each data-bit decision cycle -> data=8'h00; assert rst at data bit 4 -> no pulse, next byte 8'h3C received correctly.
